// File: rtl/ob_disp_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; seg_level maps them to pin polarity.
package ob_disp_pkg;

    localparam int DIGITS = 8;
    localparam int NIB_W  = 4;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_level(input logic [SEG_W-1:0] pattern,
                                                   input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/ob_seg_scan_hex7seg.sv
// Combinational nibble to active-high seven-segment pattern decoder.
module hex7seg
    import ob_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg
);

    assign seg = HEX7[nib];

endmodule

// File: rtl/ob_seg_scan.sv
// Time-multiplexed 8-digit hex display driver with frame snapshot, freeze,
// leading-zero blanking, inter-digit ghost blanking and a mode decimal point.
module ob_seg_scan
    import ob_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             data_i,
    input  logic [2:0]              mode_i,
    input  logic                    freeze_i,
    input  logic                    blank_lz_i,
    output logic [DIGITS-1:0]       an_o,
    output logic [SEG_W-1:0]        seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLK = CNT_W'(BLANK_CYC);
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
    localparam logic [SEG_W-1:0]  SEG_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic              DP_OFF  = ACTIVE_LOW;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [31:0]       snap;

    logic              wrap;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [2:0]        idx_nxt;
    logic [NIB_W-1:0]  nib;
    logic [31:0]       upper;
    logic              lit_digit;
    logic              ghost;
    logic [SEG_W-1:0]  seg_pat;
    logic [DIGITS-1:0] an_act;
    logic [SEG_W-1:0]  seg_act;
    logic              dp_act;

    assign wrap    = (cnt == CNT_MAX);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
    assign idx_nxt = wrap ? idx + 3'd1 : idx;

    // Digit 0 is exempt so an all-zero value still shows a single "0".
    assign nib       = snap[{idx, 2'b00} +: NIB_W];
    assign upper     = snap >> {idx, 2'b00};
    assign lit_digit = !(blank_lz_i && (idx != 3'd0) && (upper == 32'd0));
    assign ghost     = (cnt < CNT_BLK);

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_pat)
    );

    assign an_act  = (!ghost && lit_digit) ? (DIGITS'(1) << idx) : '0;
    assign seg_act = lit_digit ? seg_pat : '0;
    assign dp_act  = (mode_i == idx) && (an_act != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            snap    <= '0;
            frame_o <= 1'b0;
            an_o    <= AN_OFF;
            seg_o   <= SEG_OFF;
            dp_o    <= DP_OFF;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            // The snapshot only changes at the last cycle of a frame, so a
            // frame is never torn and freeze acts at the same point.
            if (wrap && (idx == 3'd7) && !freeze_i)
                snap <= data_i;
            frame_o <= (idx_nxt == 3'd0) && (cnt_nxt == '0);
            an_o    <= ACTIVE_LOW ? ~an_act : an_act;
            seg_o   <= seg_level(seg_act, ACTIVE_LOW);
            dp_o    <= ACTIVE_LOW ? ~dp_act : dp_act;
        end
    end

endmodule

// File: tb/tb_ob_seg_scan.sv
// Scoreboard bench for ob_seg_scan: active-low and active-high instances share
// stimulus; a monitor pops expected outputs each cycle, plus directed checks.
module tb_ob_seg_scan;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam logic [6:0] HEXT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7:0] AN_LIT [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                          8'hEF, 8'hDF, 8'hBF, 8'h7F};
    // Active-low segments for 12345678, digit 0 first.
    localparam logic [6:0] SEG_1234 [8] = '{7'h00, 7'h78, 7'h02, 7'h12,
                                            7'h19, 7'h30, 7'h24, 7'h79};
    // Active-low segments for DEADBEEF, digit 0 first.
    localparam logic [6:0] SEG_DEAD [8] = '{7'h0E, 7'h06, 7'h06, 7'h03,
                                            7'h21, 7'h08, 7'h06, 7'h21};

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic [2:0]  mode_i;
    logic        freeze_i;
    logic        blank_lz_i;
    logic [7:0]  an_l, an_h;
    logic [6:0]  seg_l, seg_h;
    logic        dp_l, dp_h, fr_l, fr_h;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    int          m_cnt, m_idx, last_cnt, last_idx;
    logic [31:0] m_snap;

    always #5 clk = ~clk;

    ob_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .data_i(data_i), .mode_i(mode_i),
        .freeze_i(freeze_i), .blank_lz_i(blank_lz_i),
        .an_o(an_l), .seg_o(seg_l), .dp_o(dp_l), .frame_o(fr_l)
    );

    ob_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .data_i(data_i), .mode_i(mode_i),
        .freeze_i(freeze_i), .blank_lz_i(blank_lz_i),
        .an_o(an_h), .seg_o(seg_h), .dp_o(dp_h), .frame_o(fr_h)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    endtask

    // One clock: the expected registered outputs are derived from the model
    // state and live inputs before the edge, then the model advances.
    task automatic step();
        exp_t e;
        logic lit;
        int   nc, ni;
        if (rst) begin
            e = '{8'h00, 7'h00, 1'b0, 1'b0};
            nc = 0; ni = 0;
        end else begin
            lit = 1'b1;
            if (blank_lz_i && m_idx != 0 && (m_snap >> (4 * m_idx)) == 32'd0) lit = 1'b0;
            e.an  = (lit && m_cnt >= BC) ? (8'd1 << m_idx) : 8'h00;
            e.seg = lit ? HEXT[(m_snap >> (4 * m_idx)) & 32'hF] : 7'h00;
            e.dp  = (e.an != 8'h00) && (int'(mode_i) == m_idx);
            nc = (m_cnt == SD - 1) ? 0 : m_cnt + 1;
            ni = (m_cnt == SD - 1) ? (m_idx + 1) % 8 : m_idx;
            e.fr = (nc == 0 && ni == 0);
        end
        last_cnt = m_cnt;
        last_idx = m_idx;
        if (rst) m_snap = 32'd0;
        else if (m_idx == 7 && m_cnt == SD - 1 && !freeze_i) m_snap = data_i;
        m_cnt = nc;
        m_idx = ni;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an_lo",    {24'd0, an_l},  {24'd0, ~e.an});
            chk("seg_lo",   {25'd0, seg_l}, {25'd0, ~e.seg});
            chk("dp_lo",    {31'd0, dp_l},  {31'd0, ~e.dp});
            chk("frame_lo", {31'd0, fr_l},  {31'd0, e.fr});
            chk("an_hi",    {24'd0, an_h},  {24'd0, e.an});
            chk("seg_hi",   {25'd0, seg_h}, {25'd0, e.seg});
            chk("dp_hi",    {31'd0, dp_h},  {31'd0, e.dp});
            chk("frame_hi", {31'd0, fr_h},  {31'd0, e.fr});
        end
    end

    task automatic run_frame(input int f);
        int pulses = 0;
        for (int s = 0; s < 8 * SD; s++) begin
            if (f == 6 && s == 14) mode_i = 3'd0;
            step();
            if (fr_l) pulses++;
            case (f)
                1, 9: begin
                    if (last_idx != 0) chk("lz_zero_an", {24'd0, an_l}, 32'hFF);
                    else if (last_cnt >= BC) chk("lz_zero_seg", {25'd0, seg_l}, 32'h40);
                end
                2: begin
                    if (last_cnt == 0) chk("ghost_an", {24'd0, an_l}, 32'hFF);
                    else begin
                        chk("scan_an", {24'd0, an_l}, {24'd0, AN_LIT[last_idx]});
                        chk("scan_seg", {25'd0, seg_l}, {25'd0, SEG_1234[last_idx]});
                    end
                end
                3: begin
                    if (last_idx >= 2) chk("lz_an_off", {24'd0, an_l}, 32'hFF);
                    else if (last_cnt >= BC)
                        chk("lz_seg", {25'd0, seg_l}, (last_idx == 1) ? 32'h08 : 32'h40);
                end
                4: if (last_idx >= 2 && last_cnt >= BC) begin
                    chk("nolz_an", {24'd0, an_l}, {24'd0, AN_LIT[last_idx]});
                    chk("nolz_seg", {25'd0, seg_l}, 32'h40);
                end
                5: chk("dp_mode5", {31'd0, dp_l},
                       (last_idx == 5 && last_cnt >= BC) ? 32'd0 : 32'd1);
                6, 7, 8: begin
                    if (last_cnt == 2)
                        chk("freeze_seg", {25'd0, seg_l}, {25'd0, SEG_DEAD[last_idx]});
                    if (f == 6 && s > 14) chk("dp_moved_off", {31'd0, dp_l}, 32'd1);
                    if (f == 7 && last_idx == 0 && last_cnt >= BC)
                        chk("dp_mode0", {31'd0, dp_l}, 32'd0);
                end
                default: ;
            endcase
        end
        if (f == 2) chk("frame_pulses", pulses, 32'd1);
    endtask

    initial begin
        m_cnt = 0; m_idx = 0; m_snap = 32'd0; last_cnt = 0; last_idx = 0;
        rst = 1'b1; data_i = 32'h12345678; mode_i = 3'd0;
        freeze_i = 1'b0; blank_lz_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", {24'd0, an_l}, 32'hFF);
            chk("rst_seg", {25'd0, seg_l}, 32'h7F);
        end
        rst = 1'b0;
        run_frame(1);
        blank_lz_i = 1'b0; data_i = 32'h000000A0;
        run_frame(2);
        blank_lz_i = 1'b1;
        run_frame(3);
        blank_lz_i = 1'b0; data_i = 32'hDEADBEEF;
        run_frame(4);
        mode_i = 3'd5; freeze_i = 1'b1; data_i = 32'h0;
        run_frame(5);
        run_frame(6);
        run_frame(7);
        freeze_i = 1'b0;
        run_frame(8);
        blank_lz_i = 1'b1;
        run_frame(9);
        // Walk to idx=4, cnt=2, then reset for a single edge.
        for (int s = 0; s < 4 * SD + 2; s++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_idx", {29'd0, dut_l.idx}, 32'd0);
        chk("mid_rst_cnt", {30'd0, dut_l.cnt}, 32'd0);
        chk("mid_rst_snap", dut_l.snap, 32'd0);
        chk("mid_rst_an", {24'd0, an_l}, 32'hFF);
        for (int s = 0; s < 8 * SD; s++) begin
            step();
            chk("post_rst_frame", {31'd0, fr_l}, (s == 8 * SD - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
